store_sequencer: RTL and testbench

//  Buffered, parametrised successor to the single-shot store writer. Captures `sequence` on each

---
 rtl/store_pkg.sv | 19 +
 rtl/store_sequencer_if.sv | 33 +++
 rtl/store_fifo.sv | 61 ++++++
 rtl/store_sequencer.sv | 94 +++++++++
 tb/tb_store_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared constants and helpers for the store sequencer slice.
// Contents: ON/OFF flag constants, default word/address widths, constant clog2.
package store_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int unsigned DEF_WORD_SIZE    = 8;
  localparam int unsigned DEF_ADDRESS_SIZE = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/store_sequencer_if.sv
// Strobe capture and memory write port bundle of the store sequencer.
// slave  : sequencer side (takes store/sequence/rewind/w_ready, drives write port and status).
// master : user/memory side (the opposite directions).
interface store_sequencer_if #(
  parameter int unsigned WORD_SIZE    = store_pkg::DEF_WORD_SIZE,
  parameter int unsigned ADDRESS_SIZE = store_pkg::DEF_ADDRESS_SIZE,
  parameter int unsigned FIFO_DEPTH   = 4
) ();

  localparam int unsigned LEVEL_W = store_pkg::clog2(FIFO_DEPTH) + 1;

  logic                    store_i;
  logic [WORD_SIZE-1:0]    sequence_i;
  logic                    rewind_i;
  logic                    w_ready_i;
  logic                    w_en_o;
  logic [ADDRESS_SIZE-1:0] w_addr_o;
  logic [WORD_SIZE-1:0]    w_data_o;
  logic [LEVEL_W-1:0]      level_o;
  logic                    overflow_o;
  logic                    done_o;

  modport slave (
    input  store_i, sequence_i, rewind_i, w_ready_i,
    output w_en_o, w_addr_o, w_data_o, level_o, overflow_o, done_o
  );

  modport master (
    output store_i, sequence_i, rewind_i, w_ready_i,
    input  w_en_o, w_addr_o, w_data_o, level_o, overflow_o, done_o
  );

endinterface

// File: rtl/store_fifo.sv
// Synchronous FIFO with a registered head word.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i,
//        head_o (registered oldest word), full_o, empty_o, level_o (words held).
module store_fifo import store_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next head: the word being written lands at the new read slot when the FIFO
  // was empty, or held one word that is popped in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    head_d   = mem_q[rd_ptr_d];
    if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/store_sequencer.sv
// Buffered store sequencer: captures a word on each store rising edge into a FIFO
// and drains it to a memory write port at auto-incrementing addresses.
// Ports: clock_i, reset_i (sync, active-high), bus (store_sequencer_if.slave):
//        store_i/sequence_i capture, rewind_i, w_ready_i/w_en_o/w_addr_o/w_data_o
//        write handshake, level_o, overflow_o (sticky), done_o (WRAP=0 end reached).
module store_sequencer import store_pkg::*; #(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned MEMORY_QTY   = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned WRAP         = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  store_sequencer_if.slave   bus
);

  localparam int unsigned LEVEL_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_QTY - 1);

  logic                    store_q;
  logic                    armed_q, armed_d;
  logic [ADDRESS_SIZE-1:0] w_addr_q, w_addr_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    push, pop, w_en, full, empty;
  logic [WORD_SIZE-1:0]    head;
  logic [LEVEL_W-1:0]      level;

  // armed_q blocks a strobe that is already high when reset releases.
  assign push = bus.store_i & ~store_q & armed_q;
  // w_en depends only on registered state, never on w_ready.
  assign w_en = ~empty & ~done_q;
  assign pop  = w_en & bus.w_ready_i;

  store_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .data_i  (bus.sequence_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Address counter, end-of-memory flag and overflow flag; rewind overrides increment.
  always_comb begin
    armed_d    = armed_q | ~bus.store_i;
    overflow_d = overflow_q | (push & full & ~pop);
    w_addr_d   = w_addr_q;
    done_d     = done_q;
    if (pop) begin
      if (w_addr_q == LAST_ADDR) begin
        if (WRAP != 0) w_addr_d = '0;
        else           done_d   = ON;
      end else begin
        w_addr_d = w_addr_q + ADDRESS_SIZE'(1);
      end
    end
    if (bus.rewind_i) begin
      w_addr_d = '0;
      done_d   = OFF;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      store_q    <= OFF;
      armed_q    <= OFF;
      w_addr_q   <= '0;
      done_q     <= OFF;
      overflow_q <= OFF;
    end else begin
      store_q    <= bus.store_i;
      armed_q    <= armed_d;
      w_addr_q   <= w_addr_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.w_en_o     = w_en;
  assign bus.w_addr_o   = w_addr_q;
  assign bus.w_data_o   = head;
  assign bus.level_o    = level;
  assign bus.overflow_o = overflow_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: a WRAP=1 instance (a) and a WRAP=0 instance (b).
module tb_store_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_sequencer_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .FIFO_DEPTH(4)) ba ();
  store_sequencer_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .FIFO_DEPTH(4)) bb ();

  store_sequencer #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(16), .FIFO_DEPTH(4), .WRAP(1))
    dut_a (.clock_i(clk), .reset_i(rst), .bus(ba));
  store_sequencer #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(16), .FIFO_DEPTH(4), .WRAP(0))
    dut_b (.clock_i(clk), .reset_i(rst), .bus(bb));

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       store;
    logic [7:0] seq;
    logic       rewind;
    logic       rdy;
    logic       en;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] lvl;
    logic       ov;
  } vec_t;

  wr_t  wr_a[$];
  wr_t  wr_b[$];
  vec_t vecs[17];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Record every accepted write of each instance.
  always @(posedge clk) begin
    if (!rst && ba.w_en_o && ba.w_ready_i) wr_a.push_back('{ba.w_addr_o, ba.w_data_o});
    if (!rst && bb.w_en_o && bb.w_ready_i) wr_b.push_back('{bb.w_addr_o, bb.w_data_o});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic store_level);
    ba.store_i = store_level; ba.sequence_i = 8'h00; ba.rewind_i = 1'b0; ba.w_ready_i = 1'b0;
    bb.store_i = 1'b0;        bb.sequence_i = 8'h00; bb.rewind_i = 1'b0; bb.w_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_a.delete();
    wr_b.delete();
  endtask

  task automatic push_a(input logic [7:0] w, input logic rdy);
    ba.store_i = 1'b1; ba.sequence_i = w; ba.w_ready_i = rdy;
    tick();
    ba.store_i = 1'b0;
    tick();
  endtask

  task automatic push_b(input logic [7:0] w, input logic rdy);
    bb.store_i = 1'b1; bb.sequence_i = w; bb.w_ready_i = rdy;
    tick();
    bb.store_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] burst [4];
    int k;

    // {store, seq, rewind, rdy} -> {w_en, w_addr, w_data, level, overflow} after the edge
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 4'd0, 8'hA5, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd1, 1'b0};
    vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd2, 1'b0};
    vecs[6]  = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd2, 1'b0};
    vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd3, 1'b0};
    vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd4, 1'b0};
    vecs[10] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd4, 1'b0};
    vecs[11] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 4'd1, 8'h01, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 4'd0, 8'h01, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 4'd1, 8'h02, 3'd3, 1'b1};
    vecs[14] = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 4'd2, 8'h03, 3'd2, 1'b1};
    vecs[15] = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 4'd3, 8'h04, 3'd1, 1'b1};
    vecs[16] = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 4'd4, 8'h00, 3'd0, 1'b1};

    // Reset state
    do_reset(1'b0);
    check("rst_w_en", 32'(ba.w_en_o), 32'd0);
    check("rst_w_addr", 32'(ba.w_addr_o), 32'd0);
    check("rst_w_data", 32'(ba.w_data_o), 32'd0);
    check("rst_level", 32'(ba.level_o), 32'd0);
    check("rst_overflow", 32'(ba.overflow_o), 32'd0);
    check("rst_done", 32'(ba.done_o), 32'd0);

    // Single capture, then fill/overflow/rewind/drain
    for (int i = 0; i < 17; i++) begin
      ba.store_i = vecs[i].store; ba.sequence_i = vecs[i].seq;
      ba.rewind_i = vecs[i].rewind; ba.w_ready_i = vecs[i].rdy;
      tick();
      check($sformatf("v%0d_w_en", i), 32'(ba.w_en_o), 32'(vecs[i].en));
      check($sformatf("v%0d_w_addr", i), 32'(ba.w_addr_o), 32'(vecs[i].addr));
      check($sformatf("v%0d_level", i), 32'(ba.level_o), 32'(vecs[i].lvl));
      check($sformatf("v%0d_overflow", i), 32'(ba.overflow_o), 32'(vecs[i].ov));
      if (vecs[i].en) check($sformatf("v%0d_w_data", i), 32'(ba.w_data_o), 32'(vecs[i].data));
    end
    ba.w_ready_i = 1'b0;
    check("vec_writes", 32'(wr_a.size()), 32'd5);
    if (wr_a.size() == 5) begin
      check("vec_wr0_addr", 32'(wr_a[0].addr), 32'd0);
      check("vec_wr0_data", 32'(wr_a[0].data), 32'hA5);
      for (int j = 1; j < 5; j++) begin
        check($sformatf("vec_wr%0d_addr", j), 32'(wr_a[j].addr), 32'(j - 1));
        check($sformatf("vec_wr%0d_data", j), 32'(wr_a[j].data), 32'(j));
      end
    end

    // WRAP=1: 17 writes, the 17th lands at address 0
    do_reset(1'b0);
    tick();
    for (int i = 0; i < 17; i++) push_a(8'(8'h40 + i), 1'b1);
    tick();
    check("wrap_writes", 32'(wr_a.size()), 32'd17);
    if (wr_a.size() == 17) begin
      for (int i = 0; i < 17; i++) begin
        check($sformatf("wrap_wr%0d_addr", i), 32'(wr_a[i].addr), 32'(i % 16));
        check($sformatf("wrap_wr%0d_data", i), 32'(wr_a[i].data), 32'(8'h40 + i));
      end
    end
    check("wrap_done", 32'(ba.done_o), 32'd0);
    check("wrap_addr", 32'(ba.w_addr_o), 32'd1);

    // WRAP=0: done after address 15, FIFO fills then overflows, rewind restarts
    do_reset(1'b0);
    tick();
    for (int i = 0; i < 16; i++) push_b(8'(8'h50 + i), 1'b1);
    check("nowrap_done", 32'(bb.done_o), 32'd1);
    check("nowrap_w_en", 32'(bb.w_en_o), 32'd0);
    check("nowrap_addr", 32'(bb.w_addr_o), 32'd15);
    for (int i = 0; i < 4; i++) push_b(8'(8'h70 + i), 1'b1);
    check("nowrap_level", 32'(bb.level_o), 32'd4);
    check("nowrap_hold_w_en", 32'(bb.w_en_o), 32'd0);
    check("nowrap_ovf_before", 32'(bb.overflow_o), 32'd0);
    push_b(8'h7F, 1'b1);
    check("nowrap_ovf_after", 32'(bb.overflow_o), 32'd1);
    check("nowrap_writes", 32'(wr_b.size()), 32'd16);
    if (wr_b.size() == 16) check("nowrap_last_addr", 32'(wr_b[15].addr), 32'd15);
    bb.w_ready_i = 1'b0; bb.rewind_i = 1'b1;
    tick();
    bb.rewind_i = 1'b0;
    check("rewind_done", 32'(bb.done_o), 32'd0);
    check("rewind_addr", 32'(bb.w_addr_o), 32'd0);
    check("rewind_w_en", 32'(bb.w_en_o), 32'd1);
    check("rewind_data", 32'(bb.w_data_o), 32'h70);
    bb.w_ready_i = 1'b1;
    tick();
    bb.w_ready_i = 1'b0;
    check("rewind_pop_addr", 32'(bb.w_addr_o), 32'd1);
    check("rewind_pop_level", 32'(bb.level_o), 32'd3);

    // w_ready toggling during a burst: held stable, nothing lost or duplicated
    do_reset(1'b0);
    tick();
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
    for (int i = 0; i < 4; i++) push_a(burst[i], 1'b0);
    check("tog_level", 32'(ba.level_o), 32'd4);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      ba.w_ready_i = (i % 2 == 0);
      tick();
      if (i % 2 == 0) k++;
      if (k < 4) begin
        check($sformatf("tog%0d_w_en", i), 32'(ba.w_en_o), 32'd1);
        check($sformatf("tog%0d_addr", i), 32'(ba.w_addr_o), 32'(k));
        check($sformatf("tog%0d_data", i), 32'(ba.w_data_o), 32'(burst[k]));
      end else begin
        check($sformatf("tog%0d_w_en", i), 32'(ba.w_en_o), 32'd0);
      end
    end
    check("tog_writes", 32'(wr_a.size()), 32'd4);
    if (wr_a.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("tog_wr%0d_addr", j), 32'(wr_a[j].addr), 32'(j));
        check($sformatf("tog_wr%0d_data", j), 32'(wr_a[j].data), 32'(burst[j]));
      end
    end

    // store high through reset release does not capture; held high captures once
    do_reset(1'b1);
    tick(); tick(); tick();
    check("held_rst_level", 32'(ba.level_o), 32'd0);
    ba.store_i = 1'b0;
    tick();
    ba.store_i = 1'b1; ba.sequence_i = 8'h81;
    for (int i = 0; i < 10; i++) tick();
    check("held_level", 32'(ba.level_o), 32'd1);
    ba.store_i = 1'b0;
    tick();
    push_a(8'h82, 1'b0); push_a(8'h83, 1'b0); push_a(8'h84, 1'b0);
    check("full_level", 32'(ba.level_o), 32'd4);
    ba.store_i = 1'b1; ba.sequence_i = 8'h99; ba.w_ready_i = 1'b1;
    tick();
    ba.store_i = 1'b0; ba.w_ready_i = 1'b0;
    check("pushpop_level", 32'(ba.level_o), 32'd4);
    check("pushpop_overflow", 32'(ba.overflow_o), 32'd0);
    check("pushpop_addr", 32'(ba.w_addr_o), 32'd1);
    check("pushpop_data", 32'(ba.w_data_o), 32'h82);

    // Reset mid-transfer, then rewind together with a pop
    do_reset(1'b0);
    tick();
    push_a(8'hB1, 1'b0); push_a(8'hB2, 1'b0); push_a(8'hB3, 1'b0);
    check("pre_rst_level", 32'(ba.level_o), 32'd3);
    check("pre_rst_w_en", 32'(ba.w_en_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_w_en", 32'(ba.w_en_o), 32'd0);
    check("mid_rst_level", 32'(ba.level_o), 32'd0);
    check("mid_rst_addr", 32'(ba.w_addr_o), 32'd0);
    tick();
    wr_a.delete();
    push_a(8'hC1, 1'b0); push_a(8'hC2, 1'b0);
    ba.w_ready_i = 1'b1;
    tick();
    check("rwpop_pre_addr", 32'(ba.w_addr_o), 32'd1);
    ba.rewind_i = 1'b1;
    tick();
    ba.rewind_i = 1'b0; ba.w_ready_i = 1'b0;
    check("rwpop_addr", 32'(ba.w_addr_o), 32'd0);
    check("rwpop_level", 32'(ba.level_o), 32'd0);
    check("rwpop_writes", 32'(wr_a.size()), 32'd2);
    if (wr_a.size() == 2) begin
      check("rwpop_wr1_addr", 32'(wr_a[1].addr), 32'd1);
      check("rwpop_wr1_data", 32'(wr_a[1].data), 32'hC2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
